cnn_stream_pool: RTL and testbench

- Streaming, parametrised 2x2 stride-2 pooling stage with optional fused ReLU, for the CNN feature-map path.
- Sits between the conv/ReLU output stream and the FC stage. It replaces fully-buffered 24x24 relu arrays with one half-row line buffer.
- Processes CH channels in parallel, one raster-order pixel per beat, with valid/ready handshakes on both sides.
- Supports max and average pooling, selectable per frame.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/pool_line_buf.sv | 29 ++
 rtl/cnn_stream_pool.sv | 150 +++++++++++++++
 tb/tb_cnn_stream_pool.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, pool-mode encoding and channel packing helper for the
// CNN streaming feature-map path.
package cnn_pkg;

  localparam int DEF_DW    = 69;
  localparam int DEF_CH    = 8;
  localparam int DEF_IMG_W = 24;
  localparam int DEF_IMG_H = 24;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Low bit of channel c in a bus packed as CH lanes of w bits each.
  function automatic int unsigned ch_lo(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for the pooling stage: one write port, one
// combinational read port, storage left unreset.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W / 2,
  parameter int WIDTH = (DEF_DW + 1) * DEF_CH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one horizontal-pair result per pooled column.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cnn_stream_pool.sv
// Streaming 2x2 stride-2 max/average pooling with optional fused ReLU.
// Raster-order input, one pixel of CH channels per beat; the upper row of
// each window is reduced to a horizontal pair result held in a half-row
// line buffer and combined when the matching lower-row pair arrives.
module cnn_stream_pool
  import cnn_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int CH      = DEF_CH,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int RELU_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pool_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             out_last,
  output logic             frame_err
);

  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int LBW      = (DW + 1) * CH;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  pool_mode_e       mode_q;
  logic [CH*DW-1:0] pair_q;
  logic [CH*DW-1:0] x_pk;
  logic [CH*DW-1:0] fin_pk;
  logic [LBW-1:0]   lb_wdata;
  logic [LBW-1:0]   lb_rdata;
  logic [LB_AW-1:0] lb_addr;
  logic             lb_we;
  logic             accept;
  logic             at_end;
  logic             emit;

  logic signed [DW-1:0] x_v [CH];
  logic signed [DW-1:0] p_v [CH];
  logic signed [DW:0]   h_v [CH];
  logic signed [DW:0]   l_v [CH];
  logic signed [DW+1:0] s_v [CH];

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign at_end   = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign lb_addr  = LB_AW'(col >> 1);
  assign lb_we    = accept && !row[0] && col[0];
  assign emit     = accept && row[0] && col[0];

  // Per-channel ReLU, horizontal pair reduction and final 2x2 reduction.
  // Average keeps the unrounded pair sum (DW+1 bits) so only the final
  // four-value sum is floored.
  always_comb begin
    x_pk     = '0;
    fin_pk   = '0;
    lb_wdata = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      x_v[c] = in_data[ch_lo(c, DW) +: DW];
      if (RELU_EN != 0 && x_v[c][DW-1]) begin
        x_v[c] = '0;
      end
      p_v[c] = pair_q[ch_lo(c, DW) +: DW];
      l_v[c] = lb_rdata[ch_lo(c, DW + 1) +: DW + 1];
      if (mode_q == POOL_AVG) begin
        h_v[c] = {x_v[c][DW-1], x_v[c]} + {p_v[c][DW-1], p_v[c]};
      end else begin
        h_v[c] = (x_v[c] > p_v[c]) ? {x_v[c][DW-1], x_v[c]} : {p_v[c][DW-1], p_v[c]};
      end
      s_v[c] = {h_v[c][DW], h_v[c]} + {l_v[c][DW], l_v[c]};
      x_pk[ch_lo(c, DW) +: DW]         = x_v[c];
      lb_wdata[ch_lo(c, DW + 1) +: DW + 1] = h_v[c];
      if (mode_q == POOL_AVG) begin
        fin_pk[ch_lo(c, DW) +: DW] = DW'(s_v[c] >>> 2);
      end else begin
        fin_pk[ch_lo(c, DW) +: DW] = (h_v[c] > l_v[c]) ? h_v[c][DW-1:0] : l_v[c][DW-1:0];
      end
    end
  end

  pool_line_buf #(
    .DEPTH(LB_DEPTH),
    .WIDTH(LBW)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(lb_wdata),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );

  // Frame position, per-frame mode latch, even-column pair capture, framing check.
  // Any in_last or the final position restarts the frame; stale line-buffer
  // entries are simply overwritten by the next frame's upper rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      mode_q    <= POOL_MAX;
      pair_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && (in_last != at_end);
      if (accept) begin
        if (row == '0 && col == '0) begin
          mode_q <= pool_mode_e'(pool_mode);
        end
        if (!col[0]) begin
          pair_q <= x_pk;
        end
        if (in_last || at_end) begin
          row <= '0;
          col <= '0;
        end else if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Single output register: loads on a completed window, clears on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= fin_pk;
      out_last  <= at_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_stream_pool.sv
// Self-checking bench for cnn_stream_pool: two instances (ReLU on/off) share
// one stimulus stream and are compared every cycle against a frame-image model.
module tb_cnn_stream_pool;

  localparam int DW  = 8;
  localparam int CH  = 2;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int DWT = CH * DW;

  logic           clk;
  logic           rst;
  logic           pool_mode;
  logic           in_valid;
  logic [DWT-1:0] in_data;
  logic           in_last;
  logic           out_ready;

  logic           in_ready_r, out_valid_r, out_last_r, frame_err_r;
  logic [DWT-1:0] out_data_r;
  logic           in_ready_n, out_valid_n, out_last_n, frame_err_n;
  logic [DWT-1:0] out_data_n;

  cnn_stream_pool #(
    .DW(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .RELU_EN(1)
  ) dut_r (
    .clk(clk), .rst(rst), .pool_mode(pool_mode),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .out_last(out_last_r), .frame_err(frame_err_r)
  );

  cnn_stream_pool #(
    .DW(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .RELU_EN(0)
  ) dut_n (
    .clk(clk), .rst(rst), .pool_mode(pool_mode),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .out_last(out_last_n), .frame_err(frame_err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DWT-1:0] dr;
    logic [DWT-1:0] dn;
    logic           last;
  } exp_t;

  exp_t q[$];
  int   n_pass;
  int   n_fail;
  int   mr, mc, mmode;
  int   img [H][W][CH];
  logic err_exp;
  bit   last_acc;
  int   stall_left;
  bit   stall_arm;
  bit   rnd_ready;
  int   gap_max;

  task automatic chk(input string tag, input logic [DWT-1:0] obs, input logic [DWT-1:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 2x2 window ending at (r,c), from plain arithmetic on the stored frame.
  function automatic logic [DWT-1:0] ref_pool(input bit relu, input int r, input int c, input int md);
    logic [DWT-1:0] res;
    int v [4];
    int m, s;
    res = '0;
    for (int ch = 0; ch < CH; ch++) begin
      v[0] = img[r-1][c-1][ch];
      v[1] = img[r-1][c][ch];
      v[2] = img[r][c-1][ch];
      v[3] = img[r][c][ch];
      s = 0;
      m = -1000000;
      for (int k = 0; k < 4; k++) begin
        if (relu && v[k] < 0) v[k] = 0;
        s += v[k];
        if (v[k] > m) m = v[k];
      end
      if (md != 0) begin
        if (s >= 0) m = s / 4;
        else        m = -((-s + 3) / 4);
      end
      res[ch*DW +: DW] = m[DW-1:0];
    end
    return res;
  endfunction

  function automatic logic [DWT-1:0] pix(input int pat, input int r, input int c);
    logic [DWT-1:0] d;
    int v;
    v = r * W + c;
    d[0 +: DW] = v[DW-1:0];
    v = -v;
    d[DW +: DW] = v[DW-1:0];
    if (pat != 0) d = DWT'($urandom());
    return d;
  endfunction

  // One clock: check all outputs against the model, advance the model, step.
  task automatic tick();
    bit exp_rdy, acc, fire, at_end, err_next;
    if (stall_arm && q.size() != 0) begin
      stall_left = 5;
      stall_arm  = 0;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    exp_rdy = !rst && (q.size() == 0 || out_ready);
    chk("in_ready_relu", in_ready_r, exp_rdy);
    chk("in_ready_norelu", in_ready_n, exp_rdy);
    chk("out_valid_relu", out_valid_r, q.size() != 0);
    chk("out_valid_norelu", out_valid_n, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data_relu", out_data_r, q[0].dr);
      chk("out_data_norelu", out_data_n, q[0].dn);
      chk("out_last_relu", out_last_r, q[0].last);
      chk("out_last_norelu", out_last_n, q[0].last);
    end
    chk("frame_err_relu", frame_err_r, err_exp);
    chk("frame_err_norelu", frame_err_n, err_exp);
    fire     = !rst && q.size() != 0 && out_ready;
    acc      = !rst && in_valid && exp_rdy;
    err_next = 1'b0;
    if (rst) begin
      q.delete();
      mr = 0;
      mc = 0;
      mmode = 0;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) begin
        if (mr == 0 && mc == 0) mmode = pool_mode;
        for (int ch = 0; ch < CH; ch++) img[mr][mc][ch] = int'($signed(in_data[ch*DW +: DW]));
        at_end = (mr == H - 1 && mc == W - 1);
        if (mr % 2 == 1 && mc % 2 == 1)
          q.push_back('{ref_pool(1, mr, mc, mmode), ref_pool(0, mr, mc, mmode), at_end});
        err_next = (in_last != at_end);
        if (in_last || at_end) begin
          mr = 0;
          mc = 0;
        end else if (mc == W - 1) begin
          mc = 0;
          mr++;
        end else begin
          mc++;
        end
      end
    end
    err_exp  = err_next;
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DWT-1:0] d, input bit lst, input bit md);
    int waited;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = lst;
    pool_mode = md;
    waited    = 0;
    last_acc  = 0;
    while (!last_acc && waited < 50) begin
      tick();
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int pat, input bit md, input int nbeats, input int last_idx, input int toggle_at);
    for (int i = 0; i < nbeats; i++)
      send_beat(pix(pat, i / W, i % W), i == last_idx, (toggle_at >= 0 && i >= toggle_at) ? !md : md);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
  endtask

  initial begin
    n_pass = 0; n_fail = 0;
    rst = 1'b1; pool_mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    mr = 0; mc = 0; mmode = 0; err_exp = 1'b0; last_acc = 0;
    stall_left = 0; stall_arm = 0; rnd_ready = 0; gap_max = 0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("reset_out_data", out_data_r, '0);
    chk("reset_out_last", out_last_r, 1'b0);
    rst = 1'b0;

    // max, ReLU vs pass-through
    send_frame(0, 0, 16, 15, -1); drain();
    // average with floor toward -inf
    send_frame(0, 1, 16, 15, -1); drain();
    // downstream stall on first output
    stall_arm = 1;
    send_frame(0, 0, 16, 15, -1); drain();
    // early in_last at (1,1), then a clean frame
    send_frame(0, 0, 6, 5, -1); drain();
    send_frame(0, 0, 16, 15, -1); drain();
    // reset mid-frame after nine beats
    send_frame(0, 0, 9, -1, -1);
    in_valid = 1'b1; in_data = pix(0, 2, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    send_frame(0, 0, 16, 15, -1); drain();
    // missing in_last at the final position
    send_frame(0, 0, 16, -1, -1); drain();
    send_frame(0, 1, 16, 15, -1); drain();
    // mode change mid-frame ignored, applied on the next frame
    send_frame(0, 0, 16, 15, 3); drain();
    send_frame(0, 1, 16, 15, -1); drain();
    // randomized data, flow control and frame lengths
    rnd_ready = 1; gap_max = 2;
    for (int k = 0; k < 8; k++) begin
      int nb;
      nb = (k % 3 == 2) ? int'($urandom_range(1, 16)) : 16;
      send_frame(1, 1'($urandom_range(0, 1)), nb, nb - 1, -1);
      drain();
    end
    rnd_ready = 0; gap_max = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
